// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   One requester's connection to the data-memory arbiter.
//   Parameter ADDR_W : word-address width of the data memory.
//   Signals
//     req    requester -> arbiter  access request; held with stable we/addr/wdata
//     we     requester -> arbiter  1 = write, 0 = read
//     addr   requester -> arbiter  byte address, word index = addr[ADDR_W+1:2]
//     wdata  requester -> arbiter  write data
//     gnt    arbiter -> requester  combinational grant, access taken at req&gnt edge
//     rvalid arbiter -> requester  registered, read data valid this cycle
//     rdata  arbiter -> requester  shared read-data bus, qualify with rvalid
//   Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 7
);
  logic              req;
  logic              we;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the core load/store path (port 0)
//   and the loader/debug port (port 1). One access per cycle, round-robin
//   ownership with a burst limit, read data returned one cycle after grant.
//
//   Parameters
//     ADDR_W     word-address width of the data memory (2**ADDR_W words)
//     MAX_BURST  max consecutive grants to the owner while the other port waits
//   Ports
//     clk          clock, all state on posedge
//     rst          synchronous reset, active-high
//     p0_if/p1_if  requester connections (dmem_arbiter_if.slave)
//     mem_en_o     memory access strobe (any grant this cycle)
//     mem_we_o     winner's write enable
//     mem_addr_o   winner's word index
//     mem_wdata_o  winner's write data
//     mem_rdata_i  memory read data, valid one cycle after a read access
//
//   Build option
//     DMEM_ARB_FIXED_PRIO_EN  defined: port 0 always wins on contention; owner and
//                             burst count are still tracked but do not steer.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     p0_if,
  dmem_arbiter_if.slave     p1_if,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  // Counter only has to reach MAX_BURST, where it saturates.
  localparam int CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_P0   = 2'b01,
    OWN_P1   = 2'b10
  } owner_e;

  // Word index of a byte address; the two byte-lane bits are dropped.
  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W+1:0] byte_addr);
    return byte_addr[ADDR_W+1:2];
  endfunction

  // Ownership state corresponding to a winning port select.
  function automatic owner_e owner_of(input logic sel);
    owner_e own;
    if (sel) begin
      own = OWN_P1;
    end else begin
      own = OWN_P0;
    end
    return own;
  endfunction

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;     // 0 = P0 granted most recently, 1 = P1
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;

  logic   win_valid_s;
  logic   win_sel_s;                    // 0 = port 0 wins, 1 = port 1 wins
  owner_e win_owner_s;
  logic   gnt0_s;
  logic   gnt1_s;
  logic   addr_lsb_unused_s;

  assign addr_lsb_unused_s = ^{p0_if.addr[1:0], p1_if.addr[1:0]};

  // Winner selection for this cycle.
  always_comb begin
    win_valid_s = 1'b0;
    win_sel_s   = 1'b0;
    if (p0_if.req && p1_if.req) begin
      win_valid_s = 1'b1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      win_sel_s = 1'b0;
`else
      // Owner keeps the memory until its tenure hits the burst limit; with no
      // owner the port that did not go last wins the tie.
      case (owner_q)
        OWN_P0:  win_sel_s = (cnt_q >= BURST_LIMIT) ? 1'b1 : 1'b0;
        OWN_P1:  win_sel_s = (cnt_q >= BURST_LIMIT) ? 1'b0 : 1'b1;
        default: win_sel_s = ~last_q;
      endcase
`endif
    end else if (p0_if.req) begin
      win_valid_s = 1'b1;
      win_sel_s   = 1'b0;
    end else if (p1_if.req) begin
      win_valid_s = 1'b1;
      win_sel_s   = 1'b1;
    end else begin
      win_valid_s = 1'b0;
      win_sel_s   = 1'b0;
    end
  end

  assign win_owner_s = owner_of(win_sel_s);
  assign gnt0_s      = win_valid_s & ~win_sel_s;
  assign gnt1_s      = win_valid_s &  win_sel_s;

  assign p0_if.gnt    = gnt0_s;
  assign p1_if.gnt    = gnt1_s;
  assign p0_if.rvalid = rvalid0_q;
  assign p1_if.rvalid = rvalid1_q;
  assign p0_if.rdata  = mem_rdata_i;
  assign p1_if.rdata  = mem_rdata_i;

  // Memory port mux: winner's access, all zero when nobody is granted.
  always_comb begin
    mem_en_o    = win_valid_s;
    mem_we_o    = 1'b0;
    mem_addr_o  = {ADDR_W{1'b0}};
    mem_wdata_o = 32'h0000_0000;
    if (win_valid_s) begin
      if (win_sel_s) begin
        mem_we_o    = p1_if.we;
        mem_addr_o  = word_index(p1_if.addr);
        mem_wdata_o = p1_if.wdata;
      end else begin
        mem_we_o    = p0_if.we;
        mem_addr_o  = word_index(p0_if.addr);
        mem_wdata_o = p0_if.wdata;
      end
    end else begin
      mem_we_o    = 1'b0;
      mem_addr_o  = {ADDR_W{1'b0}};
      mem_wdata_o = 32'h0000_0000;
    end
  end

  // Ownership / burst bookkeeping and read-return flags for the next cycle.
  always_comb begin
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    rvalid0_d = gnt0_s & ~p0_if.we;
    rvalid1_d = gnt1_s & ~p1_if.we;
    if (!win_valid_s) begin
      // Idle cycle ends the tenure; last is kept for the next tie-break.
      owner_d = OWN_NONE;
      cnt_d   = CNT_ZERO;
    end else if (win_owner_s == owner_q) begin
      if (cnt_q >= BURST_LIMIT) begin
        cnt_d = BURST_LIMIT;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      owner_d = win_owner_s;
      cnt_d   = CNT_ONE;
      last_d  = win_sel_s;
    end
  end

  // State registers; reset also drops any read return in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      cnt_q     <= CNT_ZERO;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized phase, checked
// against a grant-history reference model and a reference memory image.
module tb_dmem_arbiter;
  localparam int ADDR_W    = 7;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) p0_bus ();
  dmem_arbiter_if #(.ADDR_W(ADDR_W)) p1_bus ();

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk         (clk),
    .rst         (rst),
    .p0_if       (p0_bus),
    .p1_if       (p1_bus),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Single-port synchronous-read memory device.
  logic [31:0] dev_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dev_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= dev_mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory image, recent grant history (-1 = idle cycle).
  logic [31:0] ref_mem [DEPTH];
  int hist[$];
  int last_win = 1;

  typedef struct packed { int due; logic [31:0] data; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_winner(input logic r0, input logic r1);
    int run;
    int cur;
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    return 0;
`else
    if (hist.size() == 0 || hist[hist.size()-1] < 0) return (last_win == 0) ? 1 : 0;
    cur = hist[hist.size()-1];
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != cur) break;
      run++;
    end
    return (run >= MAX_BURST) ? 1 - cur : cur;
`endif
  endfunction

  task automatic step(input logic r0, input logic w0, input logic [ADDR_W+1:0] a0,
                      input logic [31:0] d0, input logic r1, input logic w1,
                      input logic [ADDR_W+1:0] a1, input logic [31:0] d1, output int w);
    logic              sw;
    logic [ADDR_W+1:0] sa;
    logic [31:0]       sd;
    int                idx;
    p0_bus.req = r0; p0_bus.we = w0; p0_bus.addr = a0; p0_bus.wdata = d0;
    p1_bus.req = r1; p1_bus.we = w1; p1_bus.addr = a1; p1_bus.wdata = d1;
    #1;
    w = model_winner(r0, r1);
    chk("gnt0", 32'(p0_bus.gnt), 32'(w == 0));
    chk("gnt1", 32'(p1_bus.gnt), 32'(w == 1));
    chk("mem_en", 32'(mem_en), 32'(w >= 0));
    if (w == 1) begin sw = w1; sa = a1; sd = d1; end
    else        begin sw = w0; sa = a0; sd = d0; end
    if (w >= 0) begin
      idx = int'(sa[ADDR_W+1:2]);
      chk("mem_we", 32'(mem_we), 32'(sw));
      chk("mem_addr", 32'(mem_addr), 32'(idx));
      chk("mem_wdata", mem_wdata, sd);
      if (!rst) begin
        if (sw) ref_mem[idx] = sd;
        else if (w == 0) q0.push_back('{due: cyc + 1, data: ref_mem[idx]});
        else q1.push_back('{due: cyc + 1, data: ref_mem[idx]});
      end
    end else begin
      chk("idle_mem_we", 32'(mem_we), 32'h0);
      chk("idle_mem_addr", 32'(mem_addr), 32'h0);
      chk("idle_mem_wdata", mem_wdata, 32'h0);
    end
    if (rst) begin
      hist.delete();
      last_win = 1;
    end else begin
      hist.push_back(w);
      if (w >= 0) last_win = w;
      if (hist.size() > MAX_BURST + 1) void'(hist.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle();
    int w;
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, w);
  endtask

  // Read-return monitor: one expected entry per granted read, due one cycle on.
  task automatic mon_port(input logic p, input logic rv, input logic [31:0] rd);
    exp_t e;
    logic have;
    have = 1'b0;
    e    = '0;
    if (!p) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    chk(p ? "rvalid1" : "rvalid0", 32'(rv), 32'(have));
    if (have && rv) chk(p ? "rdata1" : "rdata0", rd, e.data);
  endtask

  always @(negedge clk) begin
    mon_port(1'b0, p0_bus.rvalid, p0_bus.rdata);
    mon_port(1'b1, p1_bus.rvalid, p1_bus.rdata);
  end

  logic              pd0, pd1, wr0, wr1;
  logic [ADDR_W+1:0] ad0, ad1;
  logic [31:0]       dt0, dt1;

  initial begin
    int w;
    int rate;
    p0_bus.req = 1'b0; p0_bus.we = 1'b0; p0_bus.addr = '0; p0_bus.wdata = 32'h0;
    p1_bus.req = 1'b0; p1_bus.we = 1'b0; p1_bus.addr = '0; p1_bus.wdata = 32'h0;
    rst = 1'b1;
    @(negedge clk);

    // Reset: two cycles, nothing granted.
    idle();
    idle();
    rst = 1'b0;

    // Preload the whole memory through the loader port.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b1, 9'(i << 2),
           (i == 5) ? 32'h0000_0055 : $urandom, w);
    end
    idle();

    // Single read of word 5 on port 0.
    step(1'b1, 1'b0, 9'h014, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, w);
    chk("t2_rvalid0", 32'(p0_bus.rvalid), 32'h1);
    chk("t2_rdata", p0_bus.rdata, 32'h0000_0055);
    idle();

    // Continuous contention straight out of reset.
    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 9'h010, 32'h0, 1'b1, 1'b0, 9'h044, 32'h0, w);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      chk("t3_seq", 32'(w), 32'h0);
`else
      chk("t3_seq", 32'(w), 32'((i / MAX_BURST) % 2));
`endif
    end
    idle();

    // Idle tie-break: P1 once, idle, both -> P0.
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h008, 32'h0, w);
    idle();
    step(1'b1, 1'b0, 9'h00C, 32'h0, 1'b1, 1'b0, 9'h008, 32'h0, w);
    chk("t4_tie", 32'(w), 32'h0);
    idle();

    // P1 writes word 8, P0 reads it back.
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b1, 9'h020, 32'hDEAD_BEEF, w);
    step(1'b1, 1'b0, 9'h020, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, w);
    chk("t5_rvalid0", 32'(p0_bus.rvalid), 32'h1);
    chk("t5_rdata", p0_bus.rdata, 32'hDEAD_BEEF);
    idle();

    // Reset in the middle of P1 read traffic.
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h030, 32'h0, w);
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h034, 32'h0, w);
    rst = 1'b1;
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h038, 32'h0, w);
    chk("t6_rvalid1", 32'(p1_bus.rvalid), 32'h0);
    rst = 1'b0;
    step(1'b1, 1'b0, 9'h040, 32'h0, 1'b1, 1'b0, 9'h038, 32'h0, w);
    chk("t6_first", 32'(w), 32'h0);
    idle();

    // Randomized traffic with varying load and occasional withdrawn requests.
    pd0 = 1'b0; pd1 = 1'b0;
    wr0 = 1'b0; wr1 = 1'b0; ad0 = '0; ad1 = '0; dt0 = 32'h0; dt1 = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      rate = (c < 500) ? 95 : ((c < 1000) ? 50 : 20);
      if (pd0 && $urandom_range(99) < 3) pd0 = 1'b0;
      if (pd1 && $urandom_range(99) < 3) pd1 = 1'b0;
      if (!pd0 && $urandom_range(99) < rate) begin
        pd0 = 1'b1; wr0 = ($urandom_range(99) < 30); ad0 = 9'($urandom); dt0 = $urandom;
      end
      if (!pd1 && $urandom_range(99) < rate) begin
        pd1 = 1'b1; wr1 = ($urandom_range(99) < 30); ad1 = 9'($urandom); dt1 = $urandom;
      end
      step(pd0, wr0, ad0, dt0, pd1, wr1, ad1, dt1, w);
      if (w == 0) pd0 = 1'b0;
      if (w == 1) pd1 = 1'b0;
    end

    idle();
    idle();
    idle();
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
